cpu_branch_predictor: RTL and testbench

- Fetch-side counterpart to the execute-stage branch condition evaluator. It predicts a conditional branch's direction and target early in fetch.
- It learns from the resolved outcome (condition satisfied or not) reported back by execute.
- It holds a direct-mapped table of tagged entries, each with a 2-bit saturating counter and a target. It also raises a registered mispredict/redirect one cycle after each resolution.

---
 rtl/cpu_bp_pkg.sv | 33 +++
 rtl/cpu_branch_predictor.sv | 100 ++++++++++
 tb/tb_cpu_branch_predictor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// Entries carry a fixed-width tag so the struct is independent of table depth.
package cpu_bp_pkg;

    localparam int BP_PC_W  = 32;
    localparam int BP_TAG_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_ctr_t;

    // Tag holds pc >> (IDX_BITS+2), zero-extended to BP_TAG_W bits.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        bp_ctr_t             ctr;
    } bp_entry_t;

    localparam bp_ctr_t BP_CTR_ALLOC = WT;

    function automatic bp_ctr_t bp_ctr_inc(input bp_ctr_t c);
        return (c == ST) ? ST : bp_ctr_t'(c + 2'd1);
    endfunction

    function automatic bp_ctr_t bp_ctr_dec(input bp_ctr_t c);
        return (c == SNT) ? SNT : bp_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/cpu_branch_predictor.sv
// Direct-mapped, tagged 2-bit-counter branch predictor with registered
// mispredict/redirect reporting one cycle after each resolved branch.
module cpu_branch_predictor
    import cpu_bp_pkg::*;
#(
    parameter  int ENTRIES  = 64,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    // Update interface: update_* fields are meaningful only in a cycle where
    // update_valid is high; each such cycle is one resolved branch, consumed
    // unconditionally (no back-pressure). Ignored while rst_n is low.

    bp_entry_t table_q [ENTRIES];
    bp_entry_t table_d [ENTRIES];

    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [BP_TAG_W-1:0] fetch_tag, upd_tag;
    bp_entry_t           fetch_entry, upd_entry;
    logic                fetch_hit, upd_hit;

    assign fetch_idx   = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag   = BP_TAG_W'(fetch_pc >> (IDX_BITS + 2));
    assign fetch_entry = table_q[fetch_idx];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign predict_taken  = fetch_hit && fetch_entry.ctr[1];
    assign predict_target = predict_taken ? fetch_entry.target : fetch_pc + 32'd4;

    assign upd_idx   = update_pc[IDX_BITS+1:2];
    assign upd_tag   = BP_TAG_W'(update_pc >> (IDX_BITS + 2));
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        table_d = table_q;
        if (update_valid) begin
            if (upd_hit) begin
                if (update_taken) begin
                    table_d[upd_idx].ctr    = bp_ctr_inc(upd_entry.ctr);
                    table_d[upd_idx].target = update_target;
                end else begin
                    table_d[upd_idx].ctr    = bp_ctr_dec(upd_entry.ctr);
                end
            end else if (update_taken) begin
                // Taken miss evicts whatever aliased into this slot.
                table_d[upd_idx].valid  = 1'b1;
                table_d[upd_idx].tag    = upd_tag;
                table_d[upd_idx].target = update_target;
                table_d[upd_idx].ctr    = BP_CTR_ALLOC;
            end
        end
    end

    always_comb begin
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (update_valid) begin
            mispredict_d  = (update_taken != update_pred_taken) ||
                            (update_taken && (update_target != update_pred_target));
            redirect_pc_d = update_taken ? update_target : update_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            table_q       <= table_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Directed bench for cpu_branch_predictor (ENTRIES=64: 0x100/0x200/0x300 share index 0).
module tb_cpu_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_err;

    cpu_branch_predictor #(.ENTRIES(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_pc           (fetch_pc),
        .predict_taken      (predict_taken),
        .predict_target     (predict_target),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredict         (mispredict),
        .redirect_pc        (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
        fetch_pc = pc;
        #1;
        check({name, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_taken});
        check({name, "_target"}, predict_target, exp_target);
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                input logic pt, input logic [31:0] ptgt);
        update_valid       = 1'b1;
        update_pc          = pc;
        update_taken       = taken;
        update_target      = tgt;
        update_pred_taken  = pt;
        update_pred_target = ptgt;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic pt, input logic [31:0] ptgt);
        drive_update(pc, taken, tgt, pt, ptgt);
        tick();
        update_valid = 1'b0;
    endtask

    task automatic check_mp(input string name, input logic exp_mp, input logic [31:0] exp_rd);
        check({name, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
        check({name, "_redirect"}, redirect_pc, exp_rd);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        fetch_pc = 32'h100;
        update_valid = 1'b0;
        update_pc = 32'h0;
        update_taken = 1'b0;
        update_target = 32'h0;
        update_pred_taken = 1'b0;
        update_pred_target = 32'h0;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check_mp("reset", 1'b0, 32'h0);
        look("reset_lookup", 32'h100, 1'b0, 32'h104);
        tick();
        check_mp("post_reset", 1'b0, 32'h0);

        // First taken update: fetch in same cycle sees old state
        drive_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        look("alloc_same_cycle", 32'h100, 1'b0, 32'h104);
        tick();
        update_valid = 1'b0;
        check_mp("alloc", 1'b1, 32'h80);
        look("alloc_lookup", 32'h100, 1'b1, 32'h80);

        // Idle cycle: mispredict drops, redirect holds
        tick();
        check_mp("idle_hold", 1'b0, 32'h80);

        // Saturate at ST with correctly predicted taken updates
        do_update(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        check_mp("taken_ok1", 1'b0, 32'h80);
        do_update(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        do_update(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        check_mp("taken_ok3", 1'b0, 32'h80);
        look("sat_lookup", 32'h100, 1'b1, 32'h80);

        // ST -> WT stays taken; WT -> WNT stops predicting taken
        do_update(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        check_mp("nt1", 1'b1, 32'h104);
        look("wt_lookup", 32'h100, 1'b1, 32'h80);
        do_update(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        look("wnt_lookup", 32'h100, 1'b0, 32'h104);

        // Right direction, wrong target is still a mispredict
        do_update(32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
        check_mp("bad_target", 1'b1, 32'h80);
        look("back_to_wt", 32'h100, 1'b1, 32'h80);

        // Alias eviction: 0x200 takes over index 0
        do_update(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        check_mp("alias_alloc", 1'b1, 32'h400);
        look("evicted_lookup", 32'h100, 1'b0, 32'h104);
        look("alias_lookup", 32'h200, 1'b1, 32'h400);

        // Not-taken miss: never allocated
        do_update(32'h300, 1'b0, 32'h900, 1'b0, 32'h304);
        check_mp("nt_miss_ok", 1'b0, 32'h304);
        look("nt_miss_lookup", 32'h300, 1'b0, 32'h304);
        look("nt_miss_keeps", 32'h200, 1'b1, 32'h400);
        do_update(32'h300, 1'b0, 32'h900, 1'b1, 32'h500);
        check_mp("nt_miss_bad", 1'b1, 32'h304);

        // Same-cycle fetch/update, then reset right after the mispredict
        drive_update(32'h100, 1'b1, 32'h600, 1'b0, 32'h104);
        look("bypass_old", 32'h100, 1'b0, 32'h104);
        tick();
        check_mp("bypass_mp", 1'b1, 32'h600);
        look("bypass_new", 32'h100, 1'b1, 32'h600);
        rst_n = 1'b0;
        drive_update(32'h200, 1'b1, 32'h700, 1'b0, 32'h204);
        tick();
        update_valid = 1'b0;
        rst_n = 1'b1;
        check_mp("mid_reset", 1'b0, 32'h0);
        look("mid_reset_100", 32'h100, 1'b0, 32'h104);
        look("mid_reset_200", 32'h200, 1'b0, 32'h204);

        // PC+4 wrap
        look("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        do_update(32'hFFFF_FFFC, 1'b0, 32'h100, 1'b1, 32'h100);
        check_mp("wrap_redirect", 1'b1, 32'h0000_0000);
        tick();
        check_mp("wrap_idle", 1'b0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
